// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Shared opcodes, flag indices and FSM encoding for the ALU sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;
  localparam int OPC_W   = 4;
  localparam int SHIFT_W = 5;

  localparam logic [OPC_W-1:0] OPC_ADD  = 4'd0;
  localparam logic [OPC_W-1:0] OPC_SUB  = 4'd1;
  localparam logic [OPC_W-1:0] OPC_AND  = 4'd2;
  localparam logic [OPC_W-1:0] OPC_OR   = 4'd3;
  localparam logic [OPC_W-1:0] OPC_SLL  = 4'd4;
  localparam logic [OPC_W-1:0] OPC_XNOR = 4'd5;
  localparam logic [OPC_W-1:0] OPC_XOR  = 4'd6;
  localparam logic [OPC_W-1:0] OPC_NOR  = 4'd7;

  localparam int FLAG_CARRY = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_SIGN  = 0;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP  = 2'd2;

  function automatic logic is_illegal(input logic [OPC_W-1:0] op);
    return op > OPC_NOR;
  endfunction
endpackage

`default_nettype wire

// File: rtl/alu_seq_fifo.sv
// ============================================================================
// Module   : alu_seq_fifo
// Purpose  : Synchronous command FIFO; no bypass, push refused while full.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_seq_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Buffers tagged ALU commands, issues them one at a time to an
//            external combinational ALU and returns tagged results.
//            Optional result checker enabled by ALU_SEQ_SELFCHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OPC_W-1:0]   cmd_opcode,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic [OPC_W-1:0]   opcode,
  output logic [WIDTH-1:0]   input1,
  output logic [WIDTH-1:0]   input2,
  output logic [SHIFT_W-1:0] shiftValue,
  input  logic [WIDTH-1:0]   result,
  input  logic               carryFlag,
  input  logic               zeroFlag,
  input  logic               overFlowFlag,
  input  logic               signFlag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [3:0]         rsp_flags,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_illegal
`ifdef ALU_SEQ_SELFCHECK_EN
  ,
  output logic               chk_error
`endif
);
  localparam int ENTRY_W = OPC_W + 2*WIDTH + SHIFT_W + TAG_W;

  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               capture;
  logic               rsp_done;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [TAG_W-1:0]   iss_tag;

  logic [OPC_W-1:0]   head_opcode;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;
  logic [SHIFT_W-1:0] head_shift;
  logic [TAG_W-1:0]   head_tag;

  // Gating with rst_n keeps cmd_ready low while reset is held.
  assign cmd_ready  = rst_n && !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag};
  assign {head_opcode, head_a, head_b, head_shift, head_tag} = fifo_rdata;

  alu_seq_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = fifo_empty ? ST_IDLE : ST_ISSUE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state)
      ST_IDLE:  pop = !fifo_empty;
      ST_ISSUE: capture = 1'b1;
      ST_RESP: begin
        rsp_done = rsp_ready;
        pop      = rsp_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  // ALU drive registers hold their last issued values between commands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode     <= '0;
      input1     <= '0;
      input2     <= '0;
      shiftValue <= '0;
      iss_tag    <= '0;
    end else if (pop) begin
      opcode     <= head_opcode;
      input1     <= head_a;
      input2     <= head_b;
      shiftValue <= head_shift;
      iss_tag    <= head_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_tag     <= '0;
      rsp_illegal <= 1'b0;
    end else if (capture) begin
      rsp_valid              <= 1'b1;
      rsp_result             <= result;
      rsp_flags[FLAG_CARRY]  <= carryFlag;
      rsp_flags[FLAG_ZERO]   <= zeroFlag;
      rsp_flags[FLAG_OVF]    <= overFlowFlag;
      rsp_flags[FLAG_SIGN]   <= signFlag;
      rsp_tag                <= iss_tag;
      rsp_illegal            <= is_illegal(opcode);
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_SEQ_SELFCHECK_EN
  logic [WIDTH-1:0] model_result;
  logic             model_mismatch;

  always_comb begin
    model_result = '0;
    case (opcode)
      OPC_ADD:  model_result = input1 + input2;
      OPC_SUB:  model_result = input1 - input2;
      OPC_AND:  model_result = input1 & input2;
      OPC_OR:   model_result = input1 | input2;
      OPC_SLL:  model_result = input1 << shiftValue;
      OPC_XNOR: model_result = ~(input1 ^ input2);
      OPC_XOR:  model_result = input1 ^ input2;
      OPC_NOR:  model_result = ~(input1 | input2);
      default:  model_result = '0;
    endcase
  end

  assign model_mismatch = !is_illegal(opcode) &&
                          ((result != model_result) ||
                           (zeroFlag != (result == '0)) ||
                           (signFlag != result[WIDTH-1]));

  always_ff @(posedge clk) begin
    if (!rst_n)                          chk_error <= 1'b0;
    else if (capture && model_mismatch)  chk_error <= 1'b1;
  end
`else
  // Checker not built: no model and no chk_error port.
`endif
endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Purpose  : Directed self-checking bench with a behavioural 64-bit ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [63:0] cmd_a;
  logic [63:0] cmd_b;
  logic [4:0]  cmd_shift;
  logic [3:0]  cmd_tag;
  logic [3:0]  opcode;
  logic [63:0] input1;
  logic [63:0] input2;
  logic [4:0]  shiftValue;
  logic [63:0] result;
  logic        carryFlag;
  logic        zeroFlag;
  logic        overFlowFlag;
  logic        signFlag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [3:0]  rsp_tag;
  logic        rsp_illegal;
`ifdef ALU_SEQ_SELFCHECK_EN
  logic        chk_error;
`endif

  logic corrupt_xor = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(64), .DEPTH(4), .TAG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_shift    (cmd_shift),
    .cmd_tag      (cmd_tag),
    .opcode       (opcode),
    .input1       (input1),
    .input2       (input2),
    .shiftValue   (shiftValue),
    .result       (result),
    .carryFlag    (carryFlag),
    .zeroFlag     (zeroFlag),
    .overFlowFlag (overFlowFlag),
    .signFlag     (signFlag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_tag      (rsp_tag),
    .rsp_illegal  (rsp_illegal)
`ifdef ALU_SEQ_SELFCHECK_EN
    ,
    .chk_error    (chk_error)
`endif
  );

  // Behavioural ALU; carry on SUB is the borrow out of the 65-bit difference.
  always_comb begin
    logic [64:0] wide;
    wide         = '0;
    result       = '0;
    carryFlag    = 1'b0;
    overFlowFlag = 1'b0;
    case (opcode)
      4'd0: begin
        wide = {1'b0, input1} + {1'b0, input2};
        result = wide[63:0];
        carryFlag = wide[64];
        overFlowFlag = (input1[63] == input2[63]) && (result[63] != input1[63]);
      end
      4'd1: begin
        wide = {1'b0, input1} - {1'b0, input2};
        result = wide[63:0];
        carryFlag = wide[64];
        overFlowFlag = (input1[63] != input2[63]) && (result[63] != input1[63]);
      end
      4'd2: result = input1 & input2;
      4'd3: result = input1 | input2;
      4'd4: result = input1 << shiftValue;
      4'd5: result = ~(input1 ^ input2);
      4'd6: result = (input1 ^ input2) + (corrupt_xor ? 64'd1 : 64'd0);
      4'd7: result = ~(input1 | input2);
      default: result = '0;
    endcase
    zeroFlag = (result == '0);
    signFlag = result[63];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one command for a single cycle; assumes cmd_ready is high.
  task automatic push_cmd(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] sh, input logic [3:0] tg);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_shift  = sh;
    cmd_tag    = tg;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_cleared", {63'd0, rsp_valid}, 64'd0);
  endtask

  initial begin
    logic saw_valid;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_shift = '0; cmd_tag = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_opcode", {60'd0, opcode}, 64'd0);
    check("rst_input1", input1, 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_rsp_flags", {60'd0, rsp_flags}, 64'd0);
    check("rst_rsp_tag", {60'd0, rsp_tag}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // 1: ADD overflow to zero, exact N+3 latency
    push_cmd(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, 4'd3);
    check("t1_n1_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    check("t1_n2_valid", {63'd0, rsp_valid}, 64'd0);
    check("t1_issue_opcode", {60'd0, opcode}, 64'd0);
    check("t1_issue_input1", input1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t1_issue_input2", input2, 64'd1);
    @(negedge clk);
    check("t1_n3_valid", {63'd0, rsp_valid}, 64'd1);
    check("t1_result", rsp_result, 64'd0);
    check("t1_flags", {60'd0, rsp_flags}, 64'hC);
    check("t1_tag", {60'd0, rsp_tag}, 64'd3);
    @(negedge clk);
    check("t1_held_valid", {63'd0, rsp_valid}, 64'd1);
    check("t1_held_tag", {60'd0, rsp_tag}, 64'd3);
    accept_rsp();
    check("t1_alu_hold_input1", input1, 64'hFFFF_FFFF_FFFF_FFFF);

    // 2: backpressure, FIFO full, in-order drain at one per 2 cycles
    for (int i = 0; i < 5; i++) begin
      check("t2_ready_before_push", {63'd0, cmd_ready}, 64'd1);
      push_cmd(4'd0, 64'(i * 10), 64'(i), 5'd0, 4'(i));
    end
    check("t2_full_ready", {63'd0, cmd_ready}, 64'd0);
    check("t2_first_valid", {63'd0, rsp_valid}, 64'd1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("t2_valid", {63'd0, rsp_valid}, 64'd1);
      check("t2_tag", {60'd0, rsp_tag}, 64'(k));
      check("t2_result", rsp_result, 64'(11 * k));
      @(negedge clk);
      check("t2_gap", {63'd0, rsp_valid}, 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    check("t2_drained_ready", {63'd0, cmd_ready}, 64'd1);

    // 3: SLL 1<<31
    push_cmd(4'd4, 64'd1, 64'd0, 5'd31, 4'd1);
    wait_rsp();
    check("t3_result", rsp_result, 64'h0000_0000_8000_0000);
    check("t3_flags", {60'd0, rsp_flags}, 64'h0);
    check("t3_tag", {60'd0, rsp_tag}, 64'd1);
    check("t3_illegal", {63'd0, rsp_illegal}, 64'd0);
    accept_rsp();

    // 4: illegal opcode 9
    push_cmd(4'd9, 64'd5, 64'd3, 5'd0, 4'd2);
    wait_rsp();
    check("t4_result", rsp_result, 64'd0);
    check("t4_illegal", {63'd0, rsp_illegal}, 64'd1);
    check("t4_flags", {60'd0, rsp_flags}, 64'h4);
    accept_rsp();

    // SUB with borrow and NOR producing all ones
    push_cmd(4'd1, 64'd5, 64'd7, 5'd0, 4'd8);
    wait_rsp();
    check("sub_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_flags", {60'd0, rsp_flags}, 64'h9);
    check("sub_tag", {60'd0, rsp_tag}, 64'd8);
    accept_rsp();
    push_cmd(4'd7, 64'd0, 64'd0, 5'd0, 4'd9);
    wait_rsp();
    check("nor_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("nor_flags", {60'd0, rsp_flags}, 64'h1);
    check("nor_illegal", {63'd0, rsp_illegal}, 64'd0);
    accept_rsp();

`ifdef ALU_SEQ_SELFCHECK_EN
    check("t6_clean_chk", {63'd0, chk_error}, 64'd0);
`endif

    // 5: reset while in RESP with two commands queued
    push_cmd(4'd2, 64'hF0, 64'h3C, 5'd0, 4'd5);
    wait_rsp();
    push_cmd(4'd3, 64'd1, 64'd2, 5'd0, 4'd6);
    push_cmd(4'd3, 64'd4, 64'd8, 5'd0, 4'd7);
    check("t5_pre_valid", {63'd0, rsp_valid}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("t5_rsp_tag", {60'd0, rsp_tag}, 64'd0);
    check("t5_opcode", {60'd0, opcode}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("t5_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    rsp_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) saw_valid = 1'b1;
    end
    rsp_ready = 1'b0;
    check("t5_no_stale", {63'd0, saw_valid}, 64'd0);

`ifdef ALU_SEQ_SELFCHECK_EN
    // 6: corrupted XOR sets the sticky checker
    check("t6_after_rst_chk", {63'd0, chk_error}, 64'd0);
    corrupt_xor = 1'b1;
    push_cmd(4'd6, 64'hF0, 64'h0F, 5'd0, 4'd10);
    wait_rsp();
    check("t6_passthru", rsp_result, 64'h100);
    check("t6_chk_set", {63'd0, chk_error}, 64'd1);
    accept_rsp();
    corrupt_xor = 1'b0;
    push_cmd(4'd6, 64'hF0, 64'h0F, 5'd0, 4'd11);
    wait_rsp();
    check("t6_good_xor", rsp_result, 64'hFF);
    check("t6_chk_sticky", {63'd0, chk_error}, 64'd1);
    accept_rsp();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_chk_cleared", {63'd0, chk_error}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the 64-bit combinational ALU interface (opcode/input1/input2/shiftValue in; result plus carry/zero/overflow/sign flags out).
- Accepts tagged ALU commands over a valid/ready stream and buffers them in a small FIFO.
- Issues one command at a time to the external ALU, captures result and flags, and returns them on a tagged valid/ready response stream.
- Sits between the instruction-dispatch logic and the ALU instance.

Parameters:
- WIDTH, 64, operand/result width; must match the attached ALU.
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- TAG_W, 4, width of the command tag echoed in the response.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept.
- cmd_opcode  in  4  ALU opcode.
- cmd_a  in  WIDTH  operand 1.
- cmd_b  in  WIDTH  operand 2.
- cmd_shift  in  5  shift amount.
- cmd_tag  in  TAG_W  command tag.
- opcode  out  4  to ALU.
- input1  out  WIDTH  to ALU.
- input2  out  WIDTH  to ALU.
- shiftValue  out  5  to ALU.
- result  in  WIDTH  from ALU.
- carryFlag  in  1  from ALU.
- zeroFlag  in  1  from ALU.
- overFlowFlag  in  1  from ALU.
- signFlag  in  1  from ALU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  WIDTH  captured result.
- rsp_flags  out  4  {carry, zero, overflow, sign}.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_illegal  out  1  opcode was > 7.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO emptied; state IDLE.
  - All outputs 0: cmd_ready, rsp_valid, opcode, input1, input2, shiftValue, rsp_result, rsp_flags, rsp_tag, rsp_illegal.
  - In the first cycle after reset, cmd_ready=1.
  - Reset asserted mid-operation discards the in-flight command and the pending response; nothing is replayed.
- Command intake:
  - cmd_ready = !full.
  - Push on cmd_valid&&cmd_ready. There is no bypass, so a push is refused when full even if a pop occurs in the same cycle.
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; the count register is log2(DEPTH)+1 bits.
  - Simultaneous push and pop (not full, not empty) leaves the count unchanged.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the issue registers (opcode, input1, input2, shiftValue, tag) and go to ISSUE.
  - ISSUE: the ALU ports are driven by the registered values, so the ALU evaluates combinationally during this cycle.
    - At the end of the cycle, latch result, the four flags, tag, and illegal=(opcode>7) into the response registers.
    - Set rsp_valid=1; go to RESP.
  - RESP: rsp_valid held and all rsp_* stable until rsp_ready=1.
    - On handshake: if the FIFO is non-empty, pop the next command and go to ISSUE (same cycle); otherwise clear rsp_valid and go to IDLE.
- ALU ports keep their last issued values while in IDLE or RESP; they are not zeroed.
- Latency and throughput:
  - Command accepted in cycle N into an empty, idle block gives rsp_valid in cycle N+3: push in N, pop in N+1, issue in N+2, valid from N+3.
  - Steady-state throughput with rsp_ready=1 is one response per 2 cycles.
- Flags are passed through from the ALU unmodified. For logic ops, carry and overflow are whatever the ALU drives.
- Opcodes 8–15 are issued unchanged; the ALU default yields result 0; rsp_illegal=1.

Optional Feature:
- ALU_SEQ_SELFCHECK_EN defined:
  - Adds output port chk_error (1 bit, sticky, reset 0).
  - During ISSUE, an internal model computes the expected result for opcodes 0–7: ADD, SUB, AND, OR, SLL, XNOR, XOR, NOR.
  - chk_error is set if the ALU result differs, or if zeroFlag differs from (result==0), or if signFlag differs from result[WIDTH-1].
  - chk_error is cleared only by reset.
- Undefined: no chk_error port and no model logic.

Decomposition:
- Package alu_seq_pkg: opcode constants ADD=0, SUB=1, AND=2, OR=3, SLL=4, XNOR=5, XOR=6, NOR=7; OPC_W=4; SHIFT_W=5; flag bit indices CARRY=3, ZERO=2, OVF=1, SIGN=0; FSM state encoding.
- One sub-module: alu_seq_fifo (parameterised sync FIFO, DEPTH × {opcode, a, b, shift, tag}, outputs full/empty).

Test Plan:
1. Idle block, ALU model attached, cmd ADD a=64'hFFFF_FFFF_FFFF_FFFF b=1 tag=3 → rsp_valid at N+3, rsp_result=0, rsp_flags carry=1 and zero=1, rsp_tag=3.
2. rsp_ready=0, push 5 commands → cmd_ready low after 4 are buffered while 1 is held in RESP; release rsp_ready → 5 responses in order, tags 0..4, 2 cycles apart.
3. cmd SLL a=1 shift=31 → rsp_result=64'h8000_0000, zero=0, sign=0.
4. cmd opcode=9 → rsp_result=0, rsp_illegal=1, zero=1.
5. Assert rst_n=0 for one cycle while in RESP with 2 commands queued → rsp_valid=0 next cycle, cmd_ready=1, no stale responses afterward.
6. With ALU_SEQ_SELFCHECK_EN, ALU stub returns result+1 on XOR → chk_error=1 after that ISSUE and stays set until reset.
